// File: rtl/coin_acceptor.sv
// coin_acceptor: front end of the vending machine coin path.
//   Two raw coin-slot sensors (0.5 and 1.0 units) are synchronised and
//   debounced per channel. Each rising edge of a debounced level is one coin,
//   which is queued in a small FIFO. Coins leave as one-cycle codes on o_coin
//   while i_en is high. Coins that cannot be queued pulse o_rej.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst    synchronous active-high reset
//   i_s05    raw 0.5 sensor (asynchronous)
//   i_s10    raw 1.0 sensor (asynchronous)
//   i_en     downstream may take a coin this cycle
//   o_coin   registered coin code: 01 = 0.5, 10 = 1.0, 00 = none
//   o_rej    registered reject pulse, [0] = 0.5 coin, [1] = 1.0 coin
//   o_full   FIFO holds DEPTH entries
//   o_level  FIFO occupancy 0..DEPTH

// Per-channel synchroniser + debouncer + rising-edge detector.
module coin_acceptor_deb #(
  parameter int DEB_CYCLES = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_rise
);
  localparam int CW = $clog2(DEB_CYCLES);

  logic [1:0]    r_sync;
  logic          r_deb;
  logic          r_deb_d;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_deb   <= 1'b0;
      r_deb_d <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_raw};
      r_deb_d <= r_deb;
      if (r_sync[1] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CYCLES - 1)) begin
        // this is the DEB_CYCLES-th consecutive mismatching cycle
        r_deb <= r_sync[1];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // event is visible the cycle after the debounced level rises; it is
  // consumed (pushed) at the following edge
  assign o_rise = r_deb & ~r_deb_d;
endmodule

module coin_acceptor #(
  parameter int DEB_CYCLES = 4,
  parameter int DEPTH      = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_s05,
  input  logic                     i_s10,
  input  logic                     i_en,
  output logic [1:0]               o_coin,
  output logic [1:0]               o_rej,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int NUM_CH = 2;
  localparam int AW     = $clog2(DEPTH);
  localparam int LW     = AW + 1;

  logic [NUM_CH-1:0] w_raw;
  logic [NUM_CH-1:0] w_rise;

  assign w_raw = {i_s10, i_s05};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    coin_acceptor_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_raw  (w_raw[g]),
      .o_rise (w_rise[g])
    );
  end

  logic [1:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [LW-1:0] r_count;
  logic [1:0]    r_coin;
  logic [1:0]    r_rej;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [1:0]    w_code;
  logic [1:0]    w_rej;

  assign w_full = (r_count == LW'(DEPTH));
  assign w_pop  = i_en && (r_count != '0);
  // a pop in the same cycle frees the slot, so full only blocks without a pop
  assign w_push = (|w_rise) && (!w_full || w_pop);
  // 1.0 wins a simultaneous arrival; channel bit index doubles as code
  assign w_code = w_rise[1] ? 2'b10 : 2'b01;

  always_comb begin
    w_rej = 2'b00;
    if (w_rise[1] && w_rise[0]) w_rej[0] = 1'b1;
    if ((|w_rise) && w_full && !w_pop) w_rej = w_rej | w_code;
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr] <= w_code;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_coin  <= 2'b00;
      r_rej   <= 2'b00;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      r_count <= r_count + LW'(w_push) - LW'(w_pop);
      r_coin  <= w_pop ? r_mem[r_rd] : 2'b00;
      r_rej   <= w_rej;
    end
  end

  assign o_coin  = r_coin;
  assign o_rej   = r_rej;
  assign o_full  = w_full;
  assign o_level = r_count;
endmodule

// File: tb/tb_coin_acceptor.sv
module tb_coin_acceptor;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, s05, s10, en;
  logic [1:0] coin, rej;
  logic       full;
  logic [2:0] level;

  always #5 clk = ~clk;

  coin_acceptor #(.DEB_CYCLES(DEB), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst(rst), .i_s05(s05), .i_s10(s10), .i_en(en),
    .o_coin(coin), .o_rej(rej), .o_full(full), .o_level(level)
  );

  int n_chk = 0;
  int n_pass = 0;
  int c01, c10, r01, r10;

  typedef struct {
    logic       rst, s05, s10, en;
    logic [1:0] coin, rej;
    logic [2:0] level;
    logic       full;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic step(input logic a, input logic b, input logic e, input logic r);
    @(negedge clk);
    s05 = a; s10 = b; en = e; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_obs();
    c01 = 0; c10 = 0; r01 = 0; r10 = 0;
  endtask

  task automatic run(input logic a, input logic b, input logic e, input int n);
    for (int k = 0; k < n; k++) begin
      step(a, b, e, 1'b0);
      if (coin == 2'b01) c01++;
      if (coin == 2'b10) c10++;
      if (coin == 2'b11) c01 += 100;
      if (rej[0]) r01++;
      if (rej[1]) r10++;
    end
  endtask

  task automatic add_coin10(input logic e);
    run(1'b0, 1'b1, e, 8);
    run(1'b0, 1'b0, e, 8);
  endtask

  // reference model: queue of coin codes, sliding window of synced samples
  logic [1:0]     mq[$];
  logic [1:0]     m_s1, m_s2, m_deb, m_debp;
  logic [DEB-1:0] m_win [2];
  logic [1:0]     m_coin, m_rej;

  task automatic model_edge(input logic a, input logic b, input logic e, input logic r);
    logic [1:0] rise;
    logic       pop;
    if (r) begin
      mq.delete();
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_debp = 0;
      m_win[0] = '0; m_win[1] = '0;
      m_coin = 0; m_rej = 0;
      return;
    end
    rise   = m_deb & ~m_debp;
    pop    = e && (mq.size() > 0);
    m_coin = pop ? mq.pop_front() : 2'b00;
    m_rej  = 2'b00;
    if (rise[1] && rise[0]) m_rej[0] = 1'b1;
    if (rise[1]) begin
      if (mq.size() < DEPTH) mq.push_back(2'b10); else m_rej[1] = 1'b1;
    end else if (rise[0]) begin
      if (mq.size() < DEPTH) mq.push_back(2'b01); else m_rej[0] = 1'b1;
    end
    m_debp = m_deb;
    for (int ch = 0; ch < 2; ch++) begin
      m_win[ch] = {m_win[ch][DEB-2:0], m_s2[ch]};
      // level flips once the last DEB synced samples all disagree with it
      if (m_deb[ch] ? (m_win[ch] == '0) : (&m_win[ch])) m_deb[ch] = ~m_deb[ch];
    end
    m_s2 = m_s1;
    m_s1 = {b, a};
  endtask

  initial begin
    logic a, b, e, r;
    int   ra, rb, mode;
    rst = 1'b1; s05 = 1'b0; s10 = 1'b0; en = 1'b0;

    // table: reset, then s05 held 10 cycles with en=1, then released
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 3'd0, 1'b0};
    for (int i = 1; i < 17; i++) begin
      tbl[i] = '{1'b0, (i <= 10), 1'b0, 1'b1,
                 (i == 8) ? 2'b01 : 2'b00, 2'b00,
                 (i == 7) ? 3'd1 : 3'd0, 1'b0};
    end
    for (int i = 0; i < 17; i++) begin
      step(tbl[i].s05, tbl[i].s10, tbl[i].en, tbl[i].rst);
      chk($sformatf("vec%0d.coin", i),  coin,  tbl[i].coin);
      chk($sformatf("vec%0d.rej", i),   rej,   tbl[i].rej);
      chk($sformatf("vec%0d.level", i), level, tbl[i].level);
      chk($sformatf("vec%0d.full", i),  full,  tbl[i].full);
    end
    run(1'b0, 1'b0, 1'b1, 6);

    // short s10 pulse and 1-cycle s05 glitch are filtered
    clr_obs();
    run(1'b0, 1'b1, 1'b1, 3);
    run(1'b0, 1'b0, 1'b1, 6);
    run(1'b1, 1'b0, 1'b1, 1);
    run(1'b0, 1'b0, 1'b1, 12);
    chk("glitch.coins", c01 + c10, 0);
    chk("glitch.rej", r01 + r10, 0);
    chk("glitch.level", level, 0);

    // exactly DEB cycles high is a coin
    clr_obs();
    run(1'b0, 1'b1, 1'b1, 4);
    run(1'b0, 1'b0, 1'b1, 12);
    chk("deb4.c10", c10, 1);
    chk("deb4.c01", c01, 0);

    // five 1.0 coins with en=0: fifth rejected
    clr_obs();
    for (int i = 0; i < 4; i++) add_coin10(1'b0);
    chk("fill.level", level, 4);
    chk("fill.full", full, 1);
    chk("fill.rej", r01 + r10, 0);
    add_coin10(1'b0);
    chk("fifth.r10", r10, 1);
    chk("fifth.r01", r01, 0);
    chk("fifth.level", level, 4);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("drain%0d.coin", i), coin, 2);
      chk($sformatf("drain%0d.level", i), level, 3 - i);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drain.after", coin, 0);
    chk("drain.full", full, 0);

    // simultaneous arrival: 1.0 pushed, 0.5 rejected
    clr_obs();
    run(1'b1, 1'b1, 1'b1, 10);
    run(1'b0, 1'b0, 1'b1, 12);
    chk("both.c10", c10, 1);
    chk("both.c01", c01, 0);
    chk("both.r01", r01, 1);
    chk("both.r10", r10, 0);

    // reset mid-operation discards queue
    for (int i = 0; i < 3; i++) add_coin10(1'b0);
    chk("rstq.level", level, 3);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("rstq.level0", level, 0);
    chk("rstq.coin0", coin, 0);
    chk("rstq.full0", full, 0);
    clr_obs();
    run(1'b0, 1'b0, 1'b1, 8);
    chk("rstq.nocoin", c01 + c10, 0);

    // sensor held through reset is a new coin DEB+4 edges later
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      chk($sformatf("held.k%0d", k), coin, (k == 8) ? 1 : 0);
    end
    run(1'b0, 1'b0, 1'b1, 12);

    // full FIFO with a pop on the push edge: accepted, level stays 4
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) add_coin10(1'b0);
    clr_obs();
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, 1'b1, (k == 7), 1'b0);
      if (rej != 0) r10++;
      if (k == 7) begin
        chk("fullpop.level", level, 4);
        chk("fullpop.coin", coin, 2);
        chk("fullpop.full", full, 1);
      end
    end
    run(1'b0, 1'b0, 1'b0, 10);
    chk("fullpop.norej", r01 + r10, 0);
    chk("fullpop.level_end", level, 4);

    // randomized run against reference model
    step(1'b0, 1'b0, 1'b0, 1'b1);
    model_edge(1'b0, 1'b0, 1'b0, 1'b1);
    a = 0; b = 0; ra = 0; rb = 0; mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (ra == 0) begin a = $urandom_range(0, 1); ra = $urandom_range(1, 12); end
      if (rb == 0) begin b = $urandom_range(0, 1); rb = $urandom_range(1, 12); end
      ra--; rb--;
      if (c % 40 == 0) mode = $urandom_range(0, 2);
      e = (mode == 0) ? ($urandom_range(0, 9) < 9) :
          (mode == 1) ? ($urandom_range(0, 9) < 1) : $urandom_range(0, 1);
      r = ($urandom_range(0, 599) == 0);
      step(a, b, e, r);
      model_edge(a, b, e, r);
      chk($sformatf("rnd%0d.coin", c),  coin,  m_coin);
      chk($sformatf("rnd%0d.rej", c),   rej,   m_rej);
      chk($sformatf("rnd%0d.level", c), level, mq.size());
      chk($sformatf("rnd%0d.full", c),  full,  (mq.size() == DEPTH));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
